// File: rtl/seg_disp_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_disp_arb_pkg;

    typedef enum logic [1:0] {IDLE, ARB, HOLD} state_e;

    localparam int NIBBLE_W = 4;
    localparam int DATA_W   = 5 * NIBBLE_W;

    function automatic int OWNER_W(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seg_disp_arbiter_if.sv
// Requester/display bus between the producers (master) and the arbiter (slave).
interface seg_disp_arbiter_if #(
    parameter int N_REQ = 4
);
    import seg_disp_arb_pkg::*;

    localparam int PW = OWNER_W(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic [PW-1:0]           owner;
    logic                    disp_valid;
    logic [DATA_W-1:0]       data_tmp;

    modport master (
        output req, req_data,
        input  grant, done, owner, disp_valid, data_tmp
    );

    modport slave (
        input  req, req_data,
        output grant, done, owner, disp_valid, data_tmp
    );

endinterface

// File: rtl/seg_disp_rr_pick.sv
// Combinational round-robin pick: first set req bit after rr_ptr, wrapping.
module seg_disp_rr_pick
    import seg_disp_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int PW    = OWNER_W(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    rr_ptr_i,
    output logic             any_o,
    output logic [PW-1:0]    winner_o
);

    logic [PW-1:0] idx;

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        any_o    = |req_i;
        winner_o = '0;
        idx      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = PW'((int'(rr_ptr_i) + k) % N_REQ);
            if (req_i[idx]) winner_o = idx;
        end
    end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin owner arbitration of the 5-digit display with minimum hold time.
// Optional: SEG_DISP_ARB_PREEMPT_EN makes requester 0 preempt any other owner.
module seg_disp_arbiter
    import seg_disp_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TICK_DIV   = 50_000,
    parameter int HOLD_TICKS = 500
) (
    input  logic              clk,
    input  logic              rst,
    seg_disp_arbiter_if.slave bus
);

    localparam int PW = OWNER_W(N_REQ);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              pre_q, pre_d;

    logic              any;
    logic [PW-1:0]     winner;
    logic              tick_wrap, hold_met, pend_other, preempt;

    seg_disp_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_q),
        .any_o    (any),
        .winner_o (winner)
    );

    assign tick_wrap  = (tick_q == TICK_LAST);
    // Met at the edge where hold_cnt reaches HOLD_TICKS, so an owner holds exactly HOLD_TICKS*TICK_DIV cycles.
    assign hold_met   = (hold_q == HOLD_MAX) || (tick_wrap && (hold_q == HOLD_MAX - 1'b1));
    assign pend_other = |(bus.req & ~grant_q);

    always_comb begin
        preempt = 1'b0;
`ifdef SEG_DISP_ARB_PREEMPT_EN
        preempt = (owner_q != '0) && bus.req[0];
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        owner_d = owner_q;
        rr_d    = rr_q;
        vld_d   = vld_q;
        data_d  = data_q;
        tick_d  = tick_q;
        hold_d  = hold_q;
        pre_d   = pre_q;
        case (state_q)
            IDLE: begin
                if (any) state_d = ARB;
            end
            ARB: begin
                tick_d = '0;
                hold_d = '0;
                pre_d  = 1'b0;
                if (pre_q && bus.req[0]) begin
                    grant_d    = '0;
                    grant_d[0] = 1'b1;
                    owner_d    = '0;
                    vld_d      = 1'b1;
                    state_d    = HOLD;
                end else if (any) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    owner_d         = winner;
                    rr_d            = winner;
                    vld_d           = 1'b1;
                    state_d         = HOLD;
                end else begin
                    data_d  = '0;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                data_d = bus.req_data[int'(owner_q)*DATA_W +: DATA_W];
                if (hold_q != HOLD_MAX) begin
                    if (tick_wrap) begin
                        tick_d = '0;
                        hold_d = hold_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                if (!bus.req[owner_q] || preempt || (hold_met && pend_other)) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    owner_d = '0;
                    vld_d   = 1'b0;
                    if (bus.req[owner_q] && preempt) pre_d = 1'b1;
                    if (pend_other) begin
                        state_d = ARB;
                    end else begin
                        state_d = IDLE;
                        data_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            owner_q <= '0;
            rr_q    <= PW'(N_REQ - 1);
            vld_q   <= 1'b0;
            data_q  <= '0;
            tick_q  <= '0;
            hold_q  <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            tick_q  <= tick_d;
            hold_q  <= hold_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.owner      = owner_q;
    assign bus.disp_valid = vld_q;
    assign bus.data_tmp   = data_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with TICK_DIV=4, HOLD_TICKS=3 (12-cycle hold).
module tb_seg_disp_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   nchk = 0;

    always #5 clk = ~clk;

    seg_disp_arbiter_if #(.N_REQ(4)) bus ();

    seg_disp_arbiter #(.N_REQ(4), .TICK_DIV(4), .HOLD_TICKS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        logic [3:0] exp;
        bus.req      = '0;
        bus.req_data = '0;
        step(3);
        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_valid", bus.disp_valid, 0);
        chk("rst_data", bus.data_tmp, 0);

        // single requester, live data update, release back to idle
        rst = 1'b0;
        bus.req      = 4'b0001;
        bus.req_data = {20'h0, 20'h0, 20'h0, 20'h12345};
        step();
        chk("t1_arb_grant", bus.grant, 0);
        step();
        chk("t1_grant", bus.grant, 4'b0001);
        chk("t1_valid", bus.disp_valid, 1);
        chk("t1_data_lat", bus.data_tmp, 0);
        step();
        chk("t1_data", bus.data_tmp, 20'h12345);
        step(20);
        chk("t1_still", bus.grant, 4'b0001);
        bus.req_data = {20'h0, 20'h0, 20'h0, 20'h6789A};
        step();
        chk("t1_live", bus.data_tmp, 20'h6789A);
        bus.req = '0;
        step();
        chk("t1_done", bus.done, 4'b0001);
        chk("t1_rel_grant", bus.grant, 0);
        chk("t1_idle_data", bus.data_tmp, 0);
        step();
        chk("t1_done_pulse", bus.done, 0);

        // all requesters: round-robin order 0,1,2,3,0
        do_reset();
        bus.req      = 4'b1111;
        bus.req_data = {20'h33333, 20'h22222, 20'h11111, 20'h00000};
        step(2);
        for (int r = 0; r < 5; r++) begin
            exp = 4'b0001 << (r % 4);
            chk("rr_grant", bus.grant, exp);
            n = 0;
            while (bus.grant == exp && n < 30) begin
                step();
                n++;
            end
            chk("rr_len", n, 12);
            chk("rr_done", bus.done, exp);
            chk("rr_gap", bus.grant, 0);
            chk("rr_gap_data", bus.data_tmp, 32'h11111 * (r % 4));
            step();
        end

        // owner 2 drops early with requester 3 pending
        do_reset();
        bus.req = 4'b0100;
        step(2);
        chk("t3_grant", bus.grant, 4'b0100);
        bus.req = 4'b1100;
        step(5);
        chk("t3_no_rel", bus.grant, 4'b0100);
        bus.req = 4'b1000;
        step();
        chk("t3_done", bus.done, 4'b0100);
        chk("t3_gap", bus.grant, 0);
        step();
        chk("t3_next", bus.grant, 4'b1000);
        chk("t3_owner", bus.owner, 3);

        // reset in the middle of HOLD
        step(3);
        rst = 1'b1;
        step();
        chk("t4_grant", bus.grant, 0);
        chk("t4_done", bus.done, 0);
        chk("t4_valid", bus.disp_valid, 0);
        chk("t4_data", bus.data_tmp, 0);
        rst = 1'b0;
        bus.req = 4'b0011;
        step();
        chk("t4_done2", bus.done, 0);
        step();
        chk("t4_first", bus.grant, 4'b0001);

        // sole owner stays past hold_met until another request arrives
        do_reset();
        bus.req = 4'b0010;
        step(2);
        chk("t5_grant", bus.grant, 4'b0010);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.grant != 4'b0010 || bus.done != 0) bad++;
        end
        chk("t5_held", bad, 0);
        bus.req = 4'b0110;
        step();
        chk("t5_done", bus.done, 4'b0010);
        chk("t5_gap", bus.grant, 0);
        step();
        chk("t5_next", bus.grant, 4'b0100);

`ifdef SEG_DISP_ARB_PREEMPT_EN
        // requester 0 preempts owner 3; round-robin pointer stays at 3
        do_reset();
        bus.req = 4'b1000;
        step(2);
        chk("t6_grant", bus.grant, 4'b1000);
        step(2);
        bus.req = 4'b1001;
        step();
        chk("t6_done", bus.done, 4'b1000);
        chk("t6_gap", bus.grant, 0);
        step();
        chk("t6_pre", bus.grant, 4'b0001);
        bus.req = 4'b1111;
        n = 0;
        while (bus.grant == 4'b0001 && n < 30) begin
            step();
            n++;
        end
        chk("t6_len", n, 12);
        chk("t6_done0", bus.done, 4'b0001);
        step();
        chk("t6_rr", bus.grant, 4'b0001);
`endif

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
